// File: rtl/rv32i_types.sv
// Shared types for the branch execute path.
// Holds the widths, the issue record from the branch RS, the CDB entry,
// the branch operation enum, the conditional-branch funct3 codes and the
// resolved-result record that sits in the WB stage.
package rv32i_types;

    localparam int PC_W   = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2
    } br_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   imm;
        logic [2:0]        funct3;
        br_op_t            br_op;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
    } rs_to_br_t;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] pd;
        logic [PC_W-1:0]   data;
        logic [ROB_W-1:0]  rob;
    } cdb_entry_t;

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] pd;
        logic              rd_valid;
        logic [PC_W-1:0]   link;
        logic              taken;
        logic [PC_W-1:0]   target;
    } br_result_t;

endpackage

// File: rtl/br_unit_if.sv
// Handshake bundle between the branch RS / CDB arbiter / front end and br_unit.
//   br_issue       RS -> unit   issued op, consumed when valid && br_is_ready
//   br_is_ready    unit -> RS   unit can accept an op this cycle
//   cdb_req        unit -> CDB  resolved result, .valid is the request
//   cdb_grant      CDB -> unit  arbiter accepts cdb_req this cycle
//   redirect_*     unit -> FE   one-cycle redirect on a taken branch/jump
// master: the environment side; slave: the branch unit.
interface br_unit_if
    import rv32i_types::*;
();
    rs_to_br_t        br_issue;
    logic             br_is_ready;
    cdb_entry_t       cdb_req;
    logic             cdb_grant;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [ROB_W-1:0] redirect_rob;

    modport master (
        output br_issue, cdb_grant,
        input  br_is_ready, cdb_req, redirect_valid, redirect_pc, redirect_rob
    );

    modport slave (
        input  br_issue, cdb_grant,
        output br_is_ready, cdb_req, redirect_valid, redirect_pc, redirect_rob
    );
endinterface

// File: rtl/br_cmp.sv
// Combinational branch resolver: direction compare, target add and link.
//   funct3, br_op   operation select
//   pc, imm         op PC and immediate
//   rs1, rs2        operand values (tag-0 already forced to zero by caller)
//   taken           branch/jump taken
//   target          pc+imm, or (rs1+imm) with bit 0 cleared for JALR
//   link            pc+4
module br_cmp
    import rv32i_types::*;
(
    input  logic [2:0]      funct3_i,
    input  br_op_t          br_op_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_i,
    input  logic [PC_W-1:0] rs1_i,
    input  logic [PC_W-1:0] rs2_i,
    output logic            taken_o,
    output logic [PC_W-1:0] target_o,
    output logic [PC_W-1:0] link_o
);

    logic [PC_W-1:0] jalr_sum;

    assign jalr_sum = rs1_i + imm_i;
    assign link_o   = pc_i + PC_W'(4);

    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_i + imm_i;
        case (br_op_i)
            BR_COND: begin
                case (funct3_i)
                    F3_BEQ:  taken_o = (rs1_i == rs2_i);
                    F3_BNE:  taken_o = (rs1_i != rs2_i);
                    F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
                    F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
                    F3_BLTU: taken_o = (rs1_i <  rs2_i);
                    F3_BGEU: taken_o = (rs1_i >= rs2_i);
                    default: taken_o = 1'b0;
                endcase
            end
            BR_JAL: taken_o = 1'b1;
            BR_JALR: begin
                taken_o  = 1'b1;
                target_o = {jalr_sum[PC_W-1:1], 1'b0};
            end
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_unit.sv
// Branch functional unit: two-stage pipeline (EX captures the issue, WB holds
// the resolved result until the CDB grants it).
//   clk, rst            clock, async active-high reset
//   bus (slave)         issue / ready / CDB request+grant / redirect
//   prf_rs1/2_addr_o    PRF read tags driven from the EX stage
//   prf_rs1/2_data_i    PRF read data, same cycle
//   flush_i             synchronous kill of both stages
module br_unit
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    br_unit_if.slave          bus,
    output logic [PREG_W-1:0] prf_rs1_addr_o,
    output logic [PREG_W-1:0] prf_rs2_addr_o,
    input  logic [PC_W-1:0]   prf_rs1_data_i,
    input  logic [PC_W-1:0]   prf_rs2_data_i,
    input  logic              flush_i
);

    // ex_q.valid doubles as the EX-stage valid bit.
    rs_to_br_t  ex_q, ex_d;
    br_result_t wb_q, wb_d;
    logic       wb_valid_q, wb_valid_d;

    logic            ex_valid;
    logic            wb_free;
    logic            ex_adv;
    logic            issue_acc;
    logic [PC_W-1:0] rs1_val;
    logic [PC_W-1:0] rs2_val;
    logic            cmp_taken;
    logic [PC_W-1:0] cmp_target;
    logic [PC_W-1:0] cmp_link;
    br_result_t      ex_result;

    assign ex_valid  = ex_q.valid;
    assign wb_free   = !wb_valid_q || bus.cdb_grant;
    assign ex_adv    = ex_valid && wb_free;
    assign issue_acc = bus.br_issue.valid && bus.br_is_ready;

    assign bus.br_is_ready = !ex_valid || ex_adv;

    assign prf_rs1_addr_o = ex_q.ps1;
    assign prf_rs2_addr_o = ex_q.ps2;

    // Tag 0 is the hardwired zero register regardless of PRF contents.
    assign rs1_val = (ex_q.ps1 == '0) ? '0 : prf_rs1_data_i;
    assign rs2_val = (ex_q.ps2 == '0) ? '0 : prf_rs2_data_i;

    br_cmp u_cmp (
        .funct3_i (ex_q.funct3),
        .br_op_i  (ex_q.br_op),
        .pc_i     (ex_q.pc),
        .imm_i    (ex_q.imm),
        .rs1_i    (rs1_val),
        .rs2_i    (rs2_val),
        .taken_o  (cmp_taken),
        .target_o (cmp_target),
        .link_o   (cmp_link)
    );

    always_comb begin
        ex_result.rob      = ex_q.rob;
        ex_result.pd       = ex_q.pd;
        ex_result.rd_valid = (ex_q.br_op != BR_COND) && (ex_q.pd != '0);
        ex_result.link     = cmp_link;
        ex_result.taken    = cmp_taken;
        ex_result.target   = cmp_target;
    end

    always_comb begin
        ex_d       = ex_q;
        wb_d       = wb_q;
        wb_valid_d = wb_valid_q;

        if (ex_adv) begin
            wb_d       = ex_result;
            wb_valid_d = 1'b1;
        end else if (bus.cdb_grant) begin
            wb_valid_d = 1'b0;
        end

        if (issue_acc) begin
            ex_d = bus.br_issue;
        end else if (ex_adv) begin
            ex_d.valid = 1'b0;
        end

        // Flush overrides every other update, including a same-cycle issue.
        if (flush_i) begin
            ex_d.valid = 1'b0;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            wb_q       <= wb_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    always_comb begin
        bus.cdb_req.valid = wb_valid_q;
        bus.cdb_req.pd    = wb_q.rd_valid ? wb_q.pd : '0;
        bus.cdb_req.data  = wb_q.link;
        bus.cdb_req.rob   = wb_q.rob;
    end

    // Redirect only on the granted cycle, so a stalled WB cannot repeat it.
    assign bus.redirect_valid = wb_valid_q && bus.cdb_grant && wb_q.taken && !flush_i;
    assign bus.redirect_pc    = wb_q.target;
    assign bus.redirect_rob   = wb_q.rob;

endmodule
